// File: rtl/qft3_top_pipelined.sv
// qft3_top_pipelined: fully pipelined 3-qubit Quantum Fourier Transform on an
// 8-entry complex state vector in signed S3.4 fixed point. It accepts one vector
// per clock and has a fixed latency of 26 clocks.
//   Pipeline: input reg -> H(q2) -> CROT(pi/2, q1->q2) -> CROT(pi/4, q0->q2) -> H(q1)
//             -> CROT(pi/2, q0->q1) -> H(q0) -> bit-reversal swap reg
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous reset, ACTIVE-HIGH despite the name; clears all state
//   iXYZ_r/iXYZ_i  input amplitude of basis state |XYZ> (X = q2, Z = q0)
//   fXYZ_r/fXYZ_i  output amplitude for index k = XYZ
module qft3_top_pipelined #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned FRAC  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] i000_r,
  input  logic signed [WIDTH-1:0] i000_i,
  input  logic signed [WIDTH-1:0] i001_r,
  input  logic signed [WIDTH-1:0] i001_i,
  input  logic signed [WIDTH-1:0] i010_r,
  input  logic signed [WIDTH-1:0] i010_i,
  input  logic signed [WIDTH-1:0] i011_r,
  input  logic signed [WIDTH-1:0] i011_i,
  input  logic signed [WIDTH-1:0] i100_r,
  input  logic signed [WIDTH-1:0] i100_i,
  input  logic signed [WIDTH-1:0] i101_r,
  input  logic signed [WIDTH-1:0] i101_i,
  input  logic signed [WIDTH-1:0] i110_r,
  input  logic signed [WIDTH-1:0] i110_i,
  input  logic signed [WIDTH-1:0] i111_r,
  input  logic signed [WIDTH-1:0] i111_i,
  output logic signed [WIDTH-1:0] f000_r,
  output logic signed [WIDTH-1:0] f000_i,
  output logic signed [WIDTH-1:0] f001_r,
  output logic signed [WIDTH-1:0] f001_i,
  output logic signed [WIDTH-1:0] f010_r,
  output logic signed [WIDTH-1:0] f010_i,
  output logic signed [WIDTH-1:0] f011_r,
  output logic signed [WIDTH-1:0] f011_i,
  output logic signed [WIDTH-1:0] f100_r,
  output logic signed [WIDTH-1:0] f100_i,
  output logic signed [WIDTH-1:0] f101_r,
  output logic signed [WIDTH-1:0] f101_i,
  output logic signed [WIDTH-1:0] f110_r,
  output logic signed [WIDTH-1:0] f110_i,
  output logic signed [WIDTH-1:0] f111_r,
  output logic signed [WIDTH-1:0] f111_i
);

  localparam int unsigned SW = WIDTH + 1;      // add/sub width
  localparam int unsigned PW = 2 * WIDTH + 2;  // product width
  localparam int NumStages    = 6;
  localparam int QuarterStage = 2;             // the only pi/4 rotation

  typedef logic signed [WIDTH-1:0] amp_t;
  typedef logic signed [SW-1:0]    sum_t;
  typedef logic signed [PW-1:0]    prod_t;

  localparam prod_t CoefHalf = prod_t'(11);           // 0.6875 ~ 1/sqrt(2)
  localparam prod_t CoefUnit = prod_t'(1 << FRAC);    // 1.0
  localparam prod_t RndHalf  = prod_t'(1 << (FRAC - 1));
  localparam prod_t AmpMax   = prod_t'((1 << (WIDTH - 1)) - 1);
  localparam prod_t AmpMin   = -AmpMax - prod_t'(1);

  // Stage table: 0 H(q2), 1 CROT(pi/2,q1->q2), 2 CROT(pi/4,q0->q2),
  //              3 H(q1), 4 CROT(pi/2,q0->q1), 5 H(q0)
  function automatic logic stage_is_h(input int s);
    return (s == 0) || (s == 3) || (s == 5);
  endfunction

  function automatic int stage_tgt(input int s);
    case (s)
      0, 1, 2: return 2;
      3, 4:    return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int stage_ctl(input int s);
    return (s == 1) ? 1 : 0;
  endfunction

  function automatic logic bit_set(input int n, input int b);
    return ((n >> b) & 1) == 1;
  endfunction

  function automatic logic rot_active(input int s, input int n);
    return !stage_is_h(s) && bit_set(n, stage_tgt(s)) && bit_set(n, stage_ctl(s));
  endfunction

  function automatic int partner(input int s, input int n);
    return n ^ (1 << stage_tgt(s));
  endfunction

  function automatic int bit_rev(input int n);
    return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
  endfunction

  // Cycle-2 add/sub. Rotations are folded into add/sub + one constant multiply:
  // pi/4 -> (re-im, re+im)*11, pi/2 -> (-im, re)*16.
  function automatic sum_t stage_sum(input int s, input int n, input logic want_im,
                                     input amp_t re_n, input amp_t im_n,
                                     input amp_t re_p, input amp_t im_p);
    sum_t rn, in_, xn, xp;
    rn  = SW'(re_n);
    in_ = SW'(im_n);
    xn  = want_im ? in_ : rn;
    xp  = want_im ? SW'(im_p) : SW'(re_p);
    if (stage_is_h(s)) return bit_set(n, stage_tgt(s)) ? (xp - xn) : (xn + xp);
    if (!rot_active(s, n)) return xn;
    if (s == QuarterStage) return want_im ? (rn + in_) : (rn - in_);
    return want_im ? rn : -in_;
  endfunction

  // Pass-through lanes are multiplied by 1.0; the rounding below returns them unchanged.
  function automatic prod_t stage_coef(input int s, input int n);
    if (stage_is_h(s)) return CoefHalf;
    if (rot_active(s, n) && (s == QuarterStage)) return CoefHalf;
    return CoefUnit;
  endfunction

  // Round half away from zero, drop FRAC bits, clamp to the amplitude range.
  function automatic amp_t rnd_sat(input prod_t p);
    prod_t mag, q;
    mag = p[PW-1] ? -p : p;
    q   = (mag + RndHalf) >>> FRAC;
    if (p[PW-1]) q = -q;
    if (q > AmpMax) q = AmpMax;
    if (q < AmpMin) q = AmpMin;
    return amp_t'(q);
  endfunction

  amp_t  in_re [8];
  amp_t  in_im [8];
  amp_t  in_re_q [8];
  amp_t  in_im_q [8];
  amp_t  op_re_q [NumStages][8];
  amp_t  op_im_q [NumStages][8];
  sum_t  sum_re_d [NumStages][8];
  sum_t  sum_im_d [NumStages][8];
  sum_t  sum_re_q [NumStages][8];
  sum_t  sum_im_q [NumStages][8];
  prod_t prod_re_d [NumStages][8];
  prod_t prod_im_d [NumStages][8];
  prod_t prod_re_q [NumStages][8];
  prod_t prod_im_q [NumStages][8];
  amp_t  out_re_d [NumStages][8];
  amp_t  out_im_d [NumStages][8];
  amp_t  out_re_q [NumStages][8];
  amp_t  out_im_q [NumStages][8];
  amp_t  f_re_q [8];
  amp_t  f_im_q [8];

  always_comb begin
    in_re[0] = i000_r;  in_im[0] = i000_i;
    in_re[1] = i001_r;  in_im[1] = i001_i;
    in_re[2] = i010_r;  in_im[2] = i010_i;
    in_re[3] = i011_r;  in_im[3] = i011_i;
    in_re[4] = i100_r;  in_im[4] = i100_i;
    in_re[5] = i101_r;  in_im[5] = i101_i;
    in_re[6] = i110_r;  in_im[6] = i110_i;
    in_re[7] = i111_r;  in_im[7] = i111_i;
  end

  always_comb begin
    for (int s = 0; s < NumStages; s++) begin
      for (int n = 0; n < 8; n++) begin
        sum_re_d[s][n]  = stage_sum(s, n, 1'b0, op_re_q[s][n], op_im_q[s][n],
                                    op_re_q[s][partner(s, n)], op_im_q[s][partner(s, n)]);
        sum_im_d[s][n]  = stage_sum(s, n, 1'b1, op_re_q[s][n], op_im_q[s][n],
                                    op_re_q[s][partner(s, n)], op_im_q[s][partner(s, n)]);
        prod_re_d[s][n] = PW'(sum_re_q[s][n]) * stage_coef(s, n);
        prod_im_d[s][n] = PW'(sum_im_q[s][n]) * stage_coef(s, n);
        out_re_d[s][n]  = rnd_sat(prod_re_q[s][n]);
        out_im_d[s][n]  = rnd_sat(prod_im_q[s][n]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int n = 0; n < 8; n++) begin
        in_re_q[n] <= '0;
        in_im_q[n] <= '0;
        f_re_q[n]  <= '0;
        f_im_q[n]  <= '0;
        for (int s = 0; s < NumStages; s++) begin
          op_re_q[s][n]   <= '0;
          op_im_q[s][n]   <= '0;
          sum_re_q[s][n]  <= '0;
          sum_im_q[s][n]  <= '0;
          prod_re_q[s][n] <= '0;
          prod_im_q[s][n] <= '0;
          out_re_q[s][n]  <= '0;
          out_im_q[s][n]  <= '0;
        end
      end
    end else begin
      for (int n = 0; n < 8; n++) begin
        in_re_q[n]    <= in_re[n];
        in_im_q[n]    <= in_im[n];
        op_re_q[0][n] <= in_re_q[n];
        op_im_q[0][n] <= in_im_q[n];
        f_re_q[n]     <= out_re_q[NumStages-1][bit_rev(n)];
        f_im_q[n]     <= out_im_q[NumStages-1][bit_rev(n)];
        for (int s = 1; s < NumStages; s++) begin
          op_re_q[s][n] <= out_re_q[s-1][n];
          op_im_q[s][n] <= out_im_q[s-1][n];
        end
        for (int s = 0; s < NumStages; s++) begin
          sum_re_q[s][n]  <= sum_re_d[s][n];
          sum_im_q[s][n]  <= sum_im_d[s][n];
          prod_re_q[s][n] <= prod_re_d[s][n];
          prod_im_q[s][n] <= prod_im_d[s][n];
          out_re_q[s][n]  <= out_re_d[s][n];
          out_im_q[s][n]  <= out_im_d[s][n];
        end
      end
    end
  end

  assign f000_r = f_re_q[0];
  assign f000_i = f_im_q[0];
  assign f001_r = f_re_q[1];
  assign f001_i = f_im_q[1];
  assign f010_r = f_re_q[2];
  assign f010_i = f_im_q[2];
  assign f011_r = f_re_q[3];
  assign f011_i = f_im_q[3];
  assign f100_r = f_re_q[4];
  assign f100_i = f_im_q[4];
  assign f101_r = f_re_q[5];
  assign f101_i = f_im_q[5];
  assign f110_r = f_re_q[6];
  assign f110_i = f_im_q[6];
  assign f111_r = f_re_q[7];
  assign f111_i = f_im_q[7];

endmodule

// File: tb/tb_qft3_top_pipelined.sv
// tb_qft3_top_pipelined: directed self-checking bench for qft3_top_pipelined.
// Expected vectors were hand-derived with S3.4 arithmetic (round half away from
// zero, saturation) through the full H/CROT/swap chain.
module tb_qft3_top_pipelined;

  logic clk;
  logic rst_n;
  logic signed [7:0] ir [8];
  logic signed [7:0] ii [8];
  logic signed [7:0] fr [8];
  logic signed [7:0] fi [8];

  int exp_r [8];
  int exp_i [8];
  int checks;
  int failures;

  qft3_top_pipelined #(.WIDTH(8), .FRAC(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i000_r (ir[0]), .i000_i (ii[0]),
    .i001_r (ir[1]), .i001_i (ii[1]),
    .i010_r (ir[2]), .i010_i (ii[2]),
    .i011_r (ir[3]), .i011_i (ii[3]),
    .i100_r (ir[4]), .i100_i (ii[4]),
    .i101_r (ir[5]), .i101_i (ii[5]),
    .i110_r (ir[6]), .i110_i (ii[6]),
    .i111_r (ir[7]), .i111_i (ii[7]),
    .f000_r (fr[0]), .f000_i (fi[0]),
    .f001_r (fr[1]), .f001_i (fi[1]),
    .f010_r (fr[2]), .f010_i (fi[2]),
    .f011_r (fr[3]), .f011_i (fi[3]),
    .f100_r (fr[4]), .f100_i (fi[4]),
    .f101_r (fr[5]), .f101_i (fi[5]),
    .f110_r (fr[6]), .f110_i (fi[6]),
    .f111_r (fr[7]), .f111_i (fi[7])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // One real basis amplitude, everything else zero.
  task automatic set_basis(input int idx, input int amp);
    for (int n = 0; n < 8; n++) begin
      ir[n] = (n == idx) ? 8'(amp) : 8'sd0;
      ii[n] = 8'sd0;
    end
  endtask

  task automatic set_zero();
    for (int n = 0; n < 8; n++) begin
      ir[n] = 8'sd0;
      ii[n] = 8'sd0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int n = 0; n < 8; n++) begin
      checks++;
      assert (fr[n] === 8'(exp_r[n])) else begin
        failures++;
        $error("FAIL %s f%0d_r observed=%0d expected=%0d", tag, n, fr[n], exp_r[n]);
      end
      checks++;
      assert (fi[n] === 8'(exp_i[n])) else begin
        failures++;
        $error("FAIL %s f%0d_i observed=%0d expected=%0d", tag, n, fi[n], exp_i[n]);
      end
    end
  endtask

  task automatic exp_zero();
    exp_r = '{default: 0};
    exp_i = '{default: 0};
  endtask

  task automatic exp_b000();
    exp_r = '{6, 6, 6, 6, 6, 6, 6, 6};
    exp_i = '{default: 0};
  endtask

  task automatic exp_b110();
    exp_r = '{6, 0, -6, 0, 6, 0, -6, 0};
    exp_i = '{0, -6, 0, 6, 0, -6, 0, 6};
  endtask

  task automatic exp_b001();
    exp_r = '{6, 4, 0, -4, -6, -4, 0, 4};
    exp_i = '{0, 4, 6, 4, 0, -4, -6, -4};
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset held with nonzero inputs: everything stays zero.
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      ir[n] = 8'sd20;
      ii[n] = -8'sd3;
    end
    ticks(3);
    exp_zero();
    check_all("reset_hold");

    // |110> held: zero through edge 25, exact result on edge 26.
    rst_n = 1'b0;
    set_basis(6, 16);
    ticks(25);
    exp_zero();
    check_all("b110_edge25");
    tick();
    exp_b110();
    check_all("b110_edge26");

    // |000> -> flat spectrum of 6.
    set_basis(0, 16);
    ticks(26);
    exp_b000();
    check_all("b000");

    // |001> -> 6*e^{i*pi*k/4} with pi/4 terms rounding to magnitude 4.
    set_basis(1, 16);
    ticks(26);
    exp_b001();
    check_all("b001");

    // All-127 real input saturates f000_r at 127, no wrap, rest exactly 0.
    for (int n = 0; n < 8; n++) begin
      ir[n] = 8'sd127;
      ii[n] = 8'sd0;
    end
    ticks(26);
    exp_zero();
    exp_r[0] = 127;
    check_all("saturate");

    // Back-to-back vectors |000>, |110>, |000>, then zeros.
    set_basis(0, 16);
    tick();
    set_basis(6, 16);
    tick();
    set_basis(0, 16);
    tick();
    set_zero();
    ticks(23);
    exp_b000();
    check_all("stream_a");
    tick();
    exp_b110();
    check_all("stream_b");
    tick();
    exp_b000();
    check_all("stream_c");
    tick();
    exp_zero();
    check_all("stream_tail");

    // Fill the pipe, then assert reset between edges: outputs clear at once.
    set_basis(1, 16);
    ticks(30);
    exp_b001();
    check_all("pre_async_reset");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    exp_zero();
    check_all("async_reset");

    // After release with zero input, the cleared pipe only ever yields zero.
    tick();
    rst_n = 1'b0;
    set_zero();
    ticks(26);
    exp_zero();
    check_all("zero_in");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
